// File: rtl/dac_output_stage_pkg.sv
// ----------------------------------------------------------------------------
// dac_output_stage_pkg
//   Shared DRFM definitions for the DAC output stage: default buffer depth,
//   priming level and gain format, the FILL/STREAM state encoding, and the
//   two's-complement to offset-binary helper.
// ----------------------------------------------------------------------------
package dac_output_stage_pkg;

    localparam int DRFM_FIFO_DEPTH  = 8;   // output buffer entries (power of two)
    localparam int DRFM_PRIME_LEVEL = 4;   // occupancy required before streaming
    localparam int DRFM_SCALE_SHIFT = 15;  // fractional bits of amp_scale
    localparam int DAC_WIDTH        = 16;  // DAC word width

    typedef enum logic {
        ST_FILL   = 1'b0,
        ST_STREAM = 1'b1
    } dac_state_e;

    // Offset binary is two's complement with the sign bit inverted.
    function automatic logic [DAC_WIDTH-1:0] to_offset_binary(input logic [DAC_WIDTH-1:0] v);
        return {~v[DAC_WIDTH-1], v[DAC_WIDTH-2:0]};
    endfunction

endpackage

// File: rtl/dac_output_stage_sample_fifo.sv
// ----------------------------------------------------------------------------
// sample_fifo
//   First-word-fall-through buffer between the scaling pipeline and the DAC.
//   rd_data always shows the head entry. A write while full succeeds only if
//   a read happens in the same cycle; pointers wrap modulo DEPTH.
//
// Ports
//   M100CLK  : system clock, rising edge
//   reset    : asynchronous, active-low
//   wr_en    : write request, wr_data : word to write
//   rd_en    : pop head entry (caller only asserts when not empty)
//   rd_data  : head entry
//   count    : occupancy, 0..DEPTH
//   full     : count == DEPTH
//   empty    : count == 0
// ----------------------------------------------------------------------------
module sample_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     M100CLK,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int              AW         = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]     CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0]   PTR_ONE    = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_accept;
    logic             rd_accept;

    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign rd_accept = rd_en && !empty;
    // A full buffer can still take a word when the head leaves in the same cycle.
    assign wr_accept = wr_en && (!full || rd_accept);
    assign rd_data   = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge M100CLK or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_accept) rd_ptr <= rd_ptr + PTR_ONE;
            if (wr_accept && !rd_accept)
                count <= count + CNT_ONE;
            else if (!wr_accept && rd_accept)
                count <= count - CNT_ONE;
        end
    end

    // NOTE: storage has no reset; count/pointers gate every use of its
    // contents, so stale words are never observable and RAM mapping stays free.
    always_ff @(posedge M100CLK) begin
        if (wr_accept) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/dac_output_stage.sv
// ----------------------------------------------------------------------------
// dac_output_stage
//   Gain-scales shifted samples, rounds and saturates them to 16 bits,
//   converts to offset binary and buffers them for the DAC. A FILL/STREAM
//   controller holds the DAC interface idle until the buffer is primed and
//   returns to FILL when the buffer runs dry.
//
// Ports
//   M100CLK       : system clock, rising edge
//   reset         : asynchronous, active-low
//   sample_valid  : one-cycle strobe for sample_in / amp_scale
//   sample_in     : 32-bit two's-complement sample
//   amp_scale     : unsigned gain, SCALE_SHIFT fractional bits
//   clear_flags   : clears sticky flags and drop_count
//   dac_ready     : DAC accepts dac_data this cycle
//   dac_valid     : dac_data valid
//   dac_data      : offset-binary DAC word
//   fifo_count    : buffer occupancy
//   sat_flag      : sticky, a sample was clamped
//   overflow_flag : sticky, a sample was dropped on a full buffer
//   underrun_flag : sticky, the buffer drained while streaming
//   drop_count    : dropped samples, saturating at 0xFFFF
// ----------------------------------------------------------------------------
module dac_output_stage
    import dac_output_stage_pkg::*;
#(
    parameter int FIFO_DEPTH  = DRFM_FIFO_DEPTH,
    parameter int PRIME_LEVEL = DRFM_PRIME_LEVEL,
    parameter int SCALE_SHIFT = DRFM_SCALE_SHIFT
) (
    input  logic                          M100CLK,
    input  logic                          reset,
    input  logic                          sample_valid,
    input  logic [31:0]                   sample_in,
    input  logic [15:0]                   amp_scale,
    input  logic                          clear_flags,
    input  logic                          dac_ready,
    output logic                          dac_valid,
    output logic [DAC_WIDTH-1:0]          dac_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          sat_flag,
    output logic                          overflow_flag,
    output logic                          underrun_flag,
    output logic [15:0]                   drop_count
);

    localparam int                 CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]      PRIME_CNT  = CW'(PRIME_LEVEL);
    localparam logic [CW-1:0]      CNT_ONE    = CW'(1);
    localparam logic signed [49:0] ROUND_BIAS = 50'sd1 <<< (SCALE_SHIFT - 1);
    localparam logic signed [49:0] SAT_MAX    = 50'sd32767;
    localparam logic signed [49:0] SAT_MIN    = -50'sd32768;

    // ---------------- Stage 1: full-precision product ----------------------
    // Operands are pre-extended to the product width; the true product of a
    // 32-bit signed and 17-bit non-negative value always fits in 49 bits.
    logic signed [48:0] mul_a;
    logic signed [48:0] mul_b;
    logic signed [48:0] prod_q;
    logic               s1_valid;

    assign mul_a = {{17{sample_in[31]}}, sample_in};
    assign mul_b = {33'd0, amp_scale};

    // amp_scale only matters in the strobe cycle because the product is
    // captured only then.
    always_ff @(posedge M100CLK or negedge reset) begin
        if (!reset) begin
            prod_q   <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= sample_valid;
            if (sample_valid) prod_q <= mul_a * mul_b;
        end
    end

    // ---------------- Stage 2: round, saturate, offset binary ---------------
    logic signed [49:0]    rounded;
    logic                  clamp_hi;
    logic                  clamp_lo;
    logic [DAC_WIDTH-1:0]  sat_word;
    logic [DAC_WIDTH-1:0]  s2_data;
    logic                  s2_valid;

    always_comb begin
        // Round half up, then drop the fractional bits of the gain.
        rounded  = ($signed({prod_q[48], prod_q}) + ROUND_BIAS) >>> SCALE_SHIFT;
        clamp_hi = (rounded > SAT_MAX);
        clamp_lo = (rounded < SAT_MIN);
        if (clamp_hi)
            sat_word = 16'h7FFF;
        else if (clamp_lo)
            sat_word = 16'h8000;
        else
            sat_word = rounded[DAC_WIDTH-1:0];
    end

    always_ff @(posedge M100CLK or negedge reset) begin
        if (!reset) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) s2_data <= to_offset_binary(sat_word);
        end
    end

    // ---------------- Output buffer -----------------------------------------
    logic                  fifo_rd;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DAC_WIDTH-1:0]  fifo_head;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DAC_WIDTH)
    ) u_fifo (
        .M100CLK (M100CLK),
        .reset   (reset),
        .wr_en   (s2_valid),
        .wr_data (s2_data),
        .rd_en   (fifo_rd),
        .rd_data (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign fifo_rd  = dac_valid && dac_ready;
    // Forced to zero when idle so the DAC bus is quiet in reset and FILL.
    assign dac_data = dac_valid ? fifo_head : '0;

    // ---------------- FILL / STREAM control ---------------------------------
    dac_state_e state;
    dac_state_e state_next;
    logic       underrun_set;

    always_ff @(posedge M100CLK or negedge reset) begin
        if (!reset) state <= ST_FILL;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        dac_valid    = 1'b0;
        underrun_set = 1'b0;
        case (state)
            ST_FILL: begin
                if (fifo_count >= PRIME_CNT) state_next = ST_STREAM;
            end
            ST_STREAM: begin
                dac_valid = !fifo_empty;
                // Last entry leaves with nothing arriving behind it.
                if (dac_ready && (fifo_count == CNT_ONE) && !s2_valid) begin
                    underrun_set = 1'b1;
                    state_next   = ST_FILL;
                end
            end
            default: state_next = ST_FILL;
        endcase
    end

    // ---------------- Sticky status -----------------------------------------
    logic drop_event;

    assign drop_event = s2_valid && fifo_full && !fifo_rd;

    // A setting event in the same cycle as clear_flags takes priority.
    always_ff @(posedge M100CLK or negedge reset) begin
        if (!reset) begin
            sat_flag      <= 1'b0;
            overflow_flag <= 1'b0;
            underrun_flag <= 1'b0;
            drop_count    <= '0;
        end else begin
            if (s1_valid && (clamp_hi || clamp_lo)) sat_flag <= 1'b1;
            else if (clear_flags)                   sat_flag <= 1'b0;

            if (drop_event)       overflow_flag <= 1'b1;
            else if (clear_flags) overflow_flag <= 1'b0;

            if (underrun_set)     underrun_flag <= 1'b1;
            else if (clear_flags) underrun_flag <= 1'b0;

            if (drop_event) begin
                if (clear_flags)               drop_count <= 16'd1;
                else if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end else if (clear_flags) begin
                drop_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dac_output_stage.sv
// ----------------------------------------------------------------------------
// tb_dac_output_stage
//   Directed stimulus for dac_output_stage with a queue-based reference model
//   checked every cycle, plus hand-computed expectations at key points.
// ----------------------------------------------------------------------------
module tb_dac_output_stage;

    logic        M100CLK;
    logic        reset;
    logic        sample_valid;
    logic [31:0] sample_in;
    logic [15:0] amp_scale;
    logic        clear_flags;
    logic        dac_ready;
    logic        dac_valid;
    logic [15:0] dac_data;
    logic [3:0]  fifo_count;
    logic        sat_flag;
    logic        overflow_flag;
    logic        underrun_flag;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;

    dac_output_stage dut (
        .M100CLK       (M100CLK),
        .reset         (reset),
        .sample_valid  (sample_valid),
        .sample_in     (sample_in),
        .amp_scale     (amp_scale),
        .clear_flags   (clear_flags),
        .dac_ready     (dac_ready),
        .dac_valid     (dac_valid),
        .dac_data      (dac_data),
        .fifo_count    (fifo_count),
        .sat_flag      (sat_flag),
        .overflow_flag (overflow_flag),
        .underrun_flag (underrun_flag),
        .drop_count    (drop_count)
    );

    initial M100CLK = 1'b0;
    always #5 M100CLK = ~M100CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected DAC word {sat, offset_binary} from the arithmetic definition.
    function automatic logic [16:0] expect_word(input logic [31:0] s, input logic [15:0] a);
        longint      p;
        longint      r;
        logic [15:0] v;
        logic        sat;
        p   = longint'($signed(s)) * longint'({48'd0, a});
        r   = (p + 64'sd16384) >>> 15;
        sat = 1'b0;
        if (r > 32767) begin
            v = 16'h7FFF; sat = 1'b1;
        end else if (r < -32768) begin
            v = 16'h8000; sat = 1'b1;
        end else begin
            v = 16'(r);
        end
        return {sat, v ^ 16'h8000};
    endfunction

    // ---------------- Reference model ---------------------------------------
    // Accepted samples travel through a two-slot delay (strobe cycle, then one
    // more) before landing in an ideal queue of depth 8.
    typedef struct packed {
        logic        v;
        logic        s;
        logic [15:0] w;
    } pend_t;

    pend_t       d0, d1;
    logic [15:0] mq[$];
    bit          m_stream = 1'b0;
    bit          m_sat    = 1'b0;
    bit          m_ovf    = 1'b0;
    bit          m_und    = 1'b0;
    int          m_drop   = 0;

    initial begin
        d0 = '0;
        d1 = '0;
    end

    always @(posedge M100CLK or negedge reset) begin
        bit          rd, wr, full, und;
        logic [16:0] e;
        if (!reset) begin
            mq.delete();
            d0 = '0; d1 = '0;
            m_stream = 1'b0; m_sat = 1'b0; m_ovf = 1'b0; m_und = 1'b0; m_drop = 0;
        end else begin
            rd   = m_stream && (mq.size() != 0) && dac_ready;
            wr   = d1.v;
            full = (mq.size() == 8);
            und  = m_stream && rd && (mq.size() == 1) && !wr;
            if (clear_flags) begin
                m_sat = 1'b0; m_ovf = 1'b0; m_und = 1'b0; m_drop = 0;
            end
            if (wr && full && !rd) begin
                m_ovf = 1'b1;
                if (m_drop < 65535) m_drop++;
            end
            if (und) m_und = 1'b1;
            if (d0.v && d0.s) m_sat = 1'b1;
            if (!m_stream) m_stream = (mq.size() >= 4);
            else if (und)  m_stream = 1'b0;
            if (rd) void'(mq.pop_front());
            if (wr && (!full || rd)) mq.push_back(d1.w);
            d1 = d0;
            d0 = '0;
            if (sample_valid) begin
                e  = expect_word(sample_in, amp_scale);
                d0 = '{v: 1'b1, s: e[16], w: e[15:0]};
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge M100CLK) begin
        bit m_valid;
        m_valid = m_stream && (mq.size() != 0);
        check("dac_valid",     32'(dac_valid),     32'(m_valid));
        if (m_valid) check("dac_data", 32'(dac_data), 32'(mq[0]));
        check("fifo_count",    32'(fifo_count),    32'(mq.size()));
        check("sat_flag",      32'(sat_flag),      32'(m_sat));
        check("overflow_flag", 32'(overflow_flag), 32'(m_ovf));
        check("underrun_flag", 32'(underrun_flag), 32'(m_und));
        check("drop_count",    32'(drop_count),    32'(m_drop));
    end

    // ---------------- Stimulus helpers --------------------------------------
    task automatic tick();
        @(posedge M100CLK);
        #1;
    endtask

    task automatic send(input logic [31:0] s, input logic [15:0] a);
        sample_valid = 1'b1;
        sample_in    = s;
        amp_scale    = a;
        tick();
    endtask

    // Idle cycles also scramble amp_scale: it must not affect captured samples.
    task automatic idle(input int n);
        sample_valid = 1'b0;
        sample_in    = 32'hA5A5_A5A5;
        amp_scale    = 16'h1357;
        repeat (n) tick();
    endtask

    typedef struct packed {
        logic [31:0] s;
        logic [15:0] a;
    } vec_t;

    vec_t vecs [10];

    initial begin
        reset        = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        amp_scale    = '0;
        clear_flags  = 1'b0;
        dac_ready    = 1'b1;

        // Model pins against hand arithmetic.
        check("model_1234",  32'(expect_word(32'h0000_1234, 16'h8000)), 32'h0_9234);
        check("model_sat_hi", 32'(expect_word(32'h0001_0000, 16'h8000)), 32'h1_FFFF);
        check("model_sat_lo", 32'(expect_word(32'hFFFF_0000, 16'h8000)), 32'h1_0000);
        check("model_rnd_neg", 32'(expect_word(32'hFFFF_FFFF, 16'h4000)), 32'h0_8000);
        check("model_rnd_pos", 32'(expect_word(32'h0000_0001, 16'h4000)), 32'h0_8001);

        // Reset state.
        repeat (3) @(negedge M100CLK);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_valid", 32'(dac_valid),  32'd0);
        check("rst_data",  32'(dac_data),   32'd0);
        tick();
        reset = 1'b1;
        idle(2);

        // Priming: three samples hold, the fourth starts streaming.
        repeat (3) send(32'h0000_1234, 16'h8000);
        idle(8);
        @(negedge M100CLK);
        check("prime3_valid", 32'(dac_valid),  32'd0);
        check("prime3_count", 32'(fifo_count), 32'd3);
        send(32'h0000_1234, 16'h8000);
        sample_valid = 1'b0;
        repeat (3) @(negedge M100CLK);
        check("prime4_count", 32'(fifo_count), 32'd4);
        check("prime4_pre",   32'(dac_valid),  32'd0);
        @(negedge M100CLK);
        check("prime4_valid", 32'(dac_valid),  32'd1);
        check("prime4_data",  32'(dac_data),   32'h9234);
        repeat (5) @(negedge M100CLK);
        check("drain_underrun", 32'(underrun_flag), 32'd1);
        check("drain_valid",    32'(dac_valid),     32'd0);
        check("drain_count",    32'(fifo_count),    32'd0);

        // Saturation in both directions.
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        dac_ready   = 1'b0;
        send(32'h0001_0000, 16'h8000);
        send(32'hFFFF_0000, 16'h8000);
        send(32'h0000_1234, 16'h8000);
        send(32'h0000_1234, 16'h8000);
        idle(6);
        @(negedge M100CLK);
        check("sat_hi_data", 32'(dac_data), 32'hFFFF);
        check("sat_flag",    32'(sat_flag), 32'd1);
        dac_ready = 1'b1;
        @(negedge M100CLK);
        check("sat_lo_data", 32'(dac_data), 32'h0000);
        idle(6);

        // Overflow: ten samples into eight entries with the DAC stalled.
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        dac_ready   = 1'b0;
        for (int i = 1; i <= 10; i++) send(32'(i * 32'h111), 16'h8000);
        idle(5);
        @(negedge M100CLK);
        check("ovf_count", 32'(fifo_count),    32'd8);
        check("ovf_drop",  32'(drop_count),    32'd2);
        check("ovf_flag",  32'(overflow_flag), 32'd1);
        check("ovf_head",  32'(dac_data),      32'h8111);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        @(negedge M100CLK);
        check("clr_ovf",   32'(overflow_flag), 32'd0);
        check("clr_drop",  32'(drop_count),    32'd0);
        check("clr_sat",   32'(sat_flag),      32'd0);
        check("clr_count", 32'(fifo_count),    32'd8);

        // Drop in the same cycle as clear_flags: the drop wins.
        send(32'h0000_0999, 16'h8000);
        sample_valid = 1'b0;
        tick();
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        @(negedge M100CLK);
        check("clrwin_ovf",  32'(overflow_flag), 32'd1);
        check("clrwin_drop", 32'(drop_count),    32'd1);

        // Write while full with a simultaneous read succeeds.
        send(32'h0000_0AAA, 16'h8000);
        sample_valid = 1'b0;
        tick();
        dac_ready = 1'b1;
        tick();
        dac_ready = 1'b0;
        @(negedge M100CLK);
        check("fullrw_count", 32'(fifo_count), 32'd8);
        check("fullrw_drop",  32'(drop_count), 32'd1);
        check("fullrw_head",  32'(dac_data),   32'h8222);

        // Reset mid-stream with five buffered and two in flight.
        dac_ready = 1'b1;
        repeat (3) tick();
        dac_ready = 1'b0;
        @(negedge M100CLK);
        check("pre_rst_count", 32'(fifo_count), 32'd5);
        send(32'h0000_0100, 16'h8000);
        send(32'h0000_0200, 16'h8000);
        sample_valid = 1'b0;
        reset        = 1'b0;
        @(negedge M100CLK);
        check("midrst_count", 32'(fifo_count), 32'd0);
        check("midrst_valid", 32'(dac_valid),  32'd0);
        tick();
        reset = 1'b1;
        idle(6);
        @(negedge M100CLK);
        check("post_rst_count", 32'(fifo_count), 32'd0);
        dac_ready = 1'b1;
        repeat (3) send(32'h0000_0300, 16'h8000);
        idle(6);
        @(negedge M100CLK);
        check("reprime3_valid", 32'(dac_valid), 32'd0);
        send(32'h0000_0300, 16'h8000);
        sample_valid = 1'b0;
        repeat (4) @(negedge M100CLK);
        check("reprime4_valid", 32'(dac_valid), 32'd1);
        check("reprime4_data",  32'(dac_data),  32'h8300);
        idle(8);

        // Mixed gains, rounding edges and an intermittent DAC.
        vecs[0] = '{s: 32'hFFFF_FFFF, a: 16'h8000};
        vecs[1] = '{s: 32'h0000_0001, a: 16'h4000};
        vecs[2] = '{s: 32'hFFFF_FFFF, a: 16'h4000};
        vecs[3] = '{s: 32'h0000_7FFF, a: 16'hFFFF};
        vecs[4] = '{s: 32'h8000_0000, a: 16'h0001};
        vecs[5] = '{s: 32'h1234_5678, a: 16'h0000};
        vecs[6] = '{s: 32'h0000_0003, a: 16'h2AAA};
        vecs[7] = '{s: 32'hFFFF_C000, a: 16'h6000};
        vecs[8] = '{s: 32'h0000_4000, a: 16'hC000};
        vecs[9] = '{s: 32'h0003_0000, a: 16'h0100};
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) begin
                dac_ready = ((i + r) % 3) != 0;
                send(vecs[i].s, vecs[i].a);
                if (i % 4 == 3) idle(1);
            end
        end
        dac_ready = 1'b1;
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_output_stage.md
DAC_OUTPUT_STAGE -- requirements
Module: dac_output_stage

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: number of output buffer entries (power of two).
REQ-002 SHALL have parameter PRIME_LEVEL, default 4: FIFO occupancy needed before streaming starts.
REQ-003 SHALL have parameter SCALE_SHIFT, default 15: fractional bits of amp_scale (0x8000 = 1.0).
REQ-004 SHALL have port M100CLK, input, 1: single system clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port sample_valid, input, 1: one-cycle strobe from the frequency-shift/adder stage (arbiter_ready).
REQ-007 SHALL have port sample_in, input, 32: shifted sample, two's complement.
REQ-008 SHALL have port amp_scale, input, 16: unsigned gain.
REQ-009 SHALL have port clear_flags, input, 1: clears sticky flags and drop_count.
REQ-010 SHALL have port dac_ready, input, 1: DAC-side accept.
REQ-011 SHALL have port dac_valid, output, 1: dac_data is valid.
REQ-012 SHALL have port dac_data, output, 16: offset-binary DAC word.
REQ-013 SHALL have port fifo_count, output, log2(FIFO_DEPTH)+1: current occupancy.
REQ-014 SHALL have ports sat_flag, overflow_flag and underrun_flag, output, 1 each: sticky status flags.
REQ-015 SHALL have port drop_count, output, 16: samples dropped because the FIFO was full; saturates at 0xFFFF.

Function
REQ-016 Stage 1 SHALL, when sample_valid=1, register the product of sample_in (signed) and {1'b0,amp_scale} as a full 49-bit signed value; stage-1 valid follows sample_valid.
REQ-017 Stage 2 SHALL compute (product + 2^(SCALE_SHIFT-1)) arithmetic-shifted right by SCALE_SHIFT, saturate it to [-32768, 32767], and set sat_flag whenever clamping occurs.
REQ-018 Stage 2 SHALL convert its result to offset binary by inverting the MSB, then write it to the FIFO.
REQ-019 A sample whose sample_valid is high in cycle 0 SHALL be written to the FIFO at the end of cycle 2.
REQ-020 The FIFO SHALL be first-word-fall-through: dac_data = head entry whenever dac_valid=1.
REQ-021 A read SHALL occur when dac_valid=1 and dac_ready=1.
REQ-022 A write with the FIFO full and no simultaneous read SHALL be dropped, SHALL set overflow_flag, and SHALL increment drop_count; a write while full with a simultaneous read SHALL succeed.
REQ-023 A simultaneous read and write SHALL leave fifo_count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 The state machine SHALL have states FILL and STREAM, and reset SHALL place it in FILL.
REQ-025 In FILL, dac_valid SHALL be 0; the state SHALL go to STREAM when fifo_count >= PRIME_LEVEL, with dac_valid=1 starting on the following cycle.
REQ-026 In STREAM, dac_valid SHALL equal (fifo_count != 0).
REQ-027 If STREAM reads the last entry with no simultaneous write, underrun_flag SHALL be set and the state SHALL return to FILL.
REQ-028 clear_flags=1 SHALL zero sat_flag, overflow_flag, underrun_flag and drop_count on the next edge; a flag-setting event in the same cycle SHALL win.
REQ-029 amp_scale SHALL be sampled only in cycles where sample_valid=1; changes between samples SHALL have no effect.

Reset
REQ-030 While reset=0, all outputs SHALL be 0: dac_valid, dac_data, fifo_count, all flags, drop_count.
REQ-031 While reset=0, pipeline valids SHALL be 0, FIFO pointers SHALL be 0, and the state SHALL be FILL.
REQ-032 Reset asserted mid-stream SHALL discard all in-flight and buffered samples; the first sample after release SHALL re-prime.

Structure
REQ-033 FIFO_DEPTH, PRIME_LEVEL, SCALE_SHIFT defaults and the FILL/STREAM state encoding SHALL reside in the shared DRFM package.
REQ-034 The FIFO SHALL be a single sub-module, sample_fifo, providing storage, pointers, count, full and empty; scaling and the state machine SHALL remain in dac_output_stage.

Verification
REQ-035 amp_scale=0x8000, sample_in=0x00001234, dac_ready=1 -> after priming with 4 such samples, dac_data=0x9234.
REQ-036 amp_scale=0x8000 with sample_in=0x00010000 -> dac_data=0xFFFF and sat_flag=1; sample_in=0xFFFF0000 -> dac_data=0x0000.
REQ-037 dac_ready=1, 3 samples -> dac_valid stays 0; 4th sample -> dac_valid=1 one cycle after its FIFO write; draining all entries -> underrun_flag=1 and state FILL.
REQ-038 dac_ready=0, 10 samples -> fifo_count=8, drop_count=2, overflow_flag=1; clear_flags pulse -> flags 0 and drop_count 0, fifo_count still 8.
REQ-039 Reset pulled low while streaming with 5 entries buffered -> next cycle fifo_count=0 and dac_valid=0; after release, 4 new samples are needed before dac_valid=1.
